// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and sequencer in front of the single-ported data memory.
// Define DMEM_ARB_PERF_EN to add saturating grant/conflict/error counters on perf_o.
package riscv_32im_pkg;
    localparam logic [31:0] MAP_DMEM_BASE   = 32'h0000_0000;
    localparam logic [31:0] DMEM_SIZE_BYTES = 32'h0000_1000;
endpackage

module dmem_arbiter #(
    parameter logic [31:0] MEM_BASE = riscv_32im_pkg::MAP_DMEM_BASE,
    parameter logic [31:0] MEM_SIZE = riscv_32im_pkg::DMEM_SIZE_BYTES
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        m0_valid_i,
    output logic        m0_ready_o,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_rsp_valid_o,
    input  logic        m0_rsp_ready_i,
    output logic [31:0] m0_rdata_o,
    output logic        m0_rsp_err_o,
    input  logic        m1_valid_i,
    output logic        m1_ready_o,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_rsp_valid_o,
    input  logic        m1_rsp_ready_i,
    output logic [31:0] m1_rdata_o,
    output logic        m1_rsp_err_o,
    output logic        mem_valid_o,
    output logic        mem_ready_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_rdata_i
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [127:0] perf_o
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, RSP} state_e;

    state_e      state_q;
    logic        active_q;
    logic        rr_q;
    logic        port_q;
    logic        we_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic        idle;
    logic        gnt0;
    logic        gnt1;
    logic        accept;
    logic        in_window;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        rsp_v;
    logic        rsp_done;

    // active_q holds the ports closed until the first edge after reset release
    assign idle   = active_q && (state_q == IDLE);
    assign gnt0   = idle && m0_valid_i && (!m1_valid_i || !rr_q);
    assign gnt1   = idle && m1_valid_i && (!m0_valid_i || rr_q);
    assign accept = gnt0 || gnt1;

    assign sel_we    = gnt1 ? m1_we_i    : m0_we_i;
    assign sel_be    = gnt1 ? m1_be_i    : m0_be_i;
    assign sel_addr  = gnt1 ? m1_addr_i  : m0_addr_i;
    assign sel_wdata = gnt1 ? m1_wdata_i : m0_wdata_i;

    // Unsigned wrap makes addresses below the base fail the window test too
    assign in_window = (sel_addr - MEM_BASE) < MEM_SIZE;

    assign m0_ready_o  = gnt0;
    assign m1_ready_o  = gnt1;
    assign mem_valid_o = accept && in_window;
    assign mem_ready_o = active_q;
    assign mem_we_o    = sel_we;
    assign mem_be_o    = sel_be;
    assign mem_addr_o  = sel_addr;
    assign mem_wdata_o = sel_wdata;

    assign rsp_v          = (state_q == RSP);
    assign m0_rsp_valid_o = rsp_v && !port_q;
    assign m1_rsp_valid_o = rsp_v && port_q;
    assign m0_rdata_o     = m0_rsp_valid_o ? rdata_q : 32'h0;
    assign m1_rdata_o     = m1_rsp_valid_o ? rdata_q : 32'h0;
    assign m0_rsp_err_o   = m0_rsp_valid_o && err_q;
    assign m1_rsp_err_o   = m1_rsp_valid_o && err_q;
    assign rsp_done       = rsp_v && (port_q ? m1_rsp_ready_i : m0_rsp_ready_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
            rr_q     <= 1'b0;
            port_q   <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            active_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        port_q <= gnt1;
                        we_q   <= sel_we;
                        rr_q   <= gnt0;
                        if (in_window) begin
                            state_q <= WAIT;
                        end else begin
                            rdata_q <= 32'h0;
                            err_q   <= 1'b1;
                            state_q <= RSP;
                        end
                    end
                end
                WAIT: begin
                    assert (mem_valid_i) else $error("dmem_arbiter: no memory response in WAIT");
                    rdata_q <= we_q ? 32'h0 : mem_rdata_i;
                    err_q   <= 1'b0;
                    state_q <= RSP;
                end
                RSP: begin
                    if (rsp_done) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] grant0_cnt_q;
    logic [31:0] grant1_cnt_q;
    logic [31:0] conflict_cnt_q;
    logic [31:0] err_cnt_q;

    // Counters stick at all-ones rather than wrapping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant0_cnt_q   <= 32'h0;
            grant1_cnt_q   <= 32'h0;
            conflict_cnt_q <= 32'h0;
            err_cnt_q      <= 32'h0;
        end else begin
            if (gnt0 && (grant0_cnt_q != 32'hFFFF_FFFF)) grant0_cnt_q <= grant0_cnt_q + 32'd1;
            if (gnt1 && (grant1_cnt_q != 32'hFFFF_FFFF)) grant1_cnt_q <= grant1_cnt_q + 32'd1;
            if (idle && m0_valid_i && m1_valid_i && (conflict_cnt_q != 32'hFFFF_FFFF))
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
            if (accept && !in_window && (err_cnt_q != 32'hFFFF_FFFF)) err_cnt_q <= err_cnt_q + 32'd1;
        end
    end

    assign perf_o = {err_cnt_q, conflict_cnt_q, grant1_cnt_q, grant0_cnt_q};
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a 1-cycle-latency memory model.
module tb_dmem_arbiter;
    import riscv_32im_pkg::*;

    localparam logic [31:0] MEM_BASE = MAP_DMEM_BASE;
    localparam logic [31:0] MEM_SIZE = DMEM_SIZE_BYTES;
    localparam int WORDS = int'(MEM_SIZE / 4);
    localparam int IW    = $clog2(WORDS);

    logic        clk;
    logic        rstN;
    logic        m0Valid, m0Ready, m0We, m0RspValid, m0RspReady, m0Err;
    logic [3:0]  m0Be;
    logic [31:0] m0Addr, m0Wdata, m0Rdata;
    logic        m1Valid, m1Ready, m1We, m1RspValid, m1RspReady, m1Err;
    logic [3:0]  m1Be;
    logic [31:0] m1Addr, m1Wdata, m1Rdata;
    logic        memValid, memReadyO, memWe, memValidIn;
    logic [3:0]  memBe;
    logic [31:0] memAddr, memWdata, memRdataIn;

    int checks;
    int failures;
    logic rrExp;

    dmem_arbiter dut (
        .clk_i          (clk),
        .rst_ni         (rstN),
        .m0_valid_i     (m0Valid),
        .m0_ready_o     (m0Ready),
        .m0_we_i        (m0We),
        .m0_be_i        (m0Be),
        .m0_addr_i      (m0Addr),
        .m0_wdata_i     (m0Wdata),
        .m0_rsp_valid_o (m0RspValid),
        .m0_rsp_ready_i (m0RspReady),
        .m0_rdata_o     (m0Rdata),
        .m0_rsp_err_o   (m0Err),
        .m1_valid_i     (m1Valid),
        .m1_ready_o     (m1Ready),
        .m1_we_i        (m1We),
        .m1_be_i        (m1Be),
        .m1_addr_i      (m1Addr),
        .m1_wdata_i     (m1Wdata),
        .m1_rsp_valid_o (m1RspValid),
        .m1_rsp_ready_i (m1RspReady),
        .m1_rdata_o     (m1Rdata),
        .m1_rsp_err_o   (m1Err),
        .mem_valid_o    (memValid),
        .mem_ready_o    (memReadyO),
        .mem_we_o       (memWe),
        .mem_be_o       (memBe),
        .mem_addr_o     (memAddr),
        .mem_wdata_o    (memWdata),
        .mem_valid_i    (memValidIn),
        .mem_rdata_i    (memRdataIn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: registered response one cycle after issue; writes return junk data
    logic [31:0] memArray [WORDS];
    logic        memInit;
    logic [31:0] memOff;
    assign memOff = memAddr - MEM_BASE;

    always @(posedge clk) begin
        memValidIn <= memValid;
        if (memInit) begin
            for (int i = 0; i < WORDS; i++) memArray[i] <= 32'h0;
            memArray[0]       <= 32'hDEAD_BEEF;
            memArray[1]       <= 32'h1357_9BDF;
            memArray[WORDS-1] <= 32'hCAFE_F00D;
        end else if (memValid) begin
            if (memWe) begin
                for (int b = 0; b < 4; b++)
                    if (memBe[b]) memArray[memOff[IW+1:2]][8*b +: 8] <= memWdata[8*b +: 8];
                memRdataIn <= 32'hFFFF_FFFF;
            end else begin
                memRdataIn <= memArray[memOff[IW+1:2]];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic setReq(input int p, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 0) begin
            m0Valid = 1'b1; m0We = we; m0Be = be; m0Addr = addr; m0Wdata = wdata;
        end else begin
            m1Valid = 1'b1; m1We = we; m1Be = be; m1Addr = addr; m1Wdata = wdata;
        end
    endtask

    // Ungranted ports get scrambled fields to show they are ignored
    task automatic clearReq(input int p);
        if (p == 0) begin
            m0Valid = 1'b0; m0Addr = $urandom; m0Wdata = $urandom; m0We = 1'b1;
        end else begin
            m1Valid = 1'b0; m1Addr = $urandom; m1Wdata = $urandom; m1We = 1'b1;
        end
    endtask

    function automatic logic rspValidOf(input int p);
        return (p == 0) ? m0RspValid : m1RspValid;
    endfunction

    function automatic logic [31:0] rdataOf(input int p);
        return (p == 0) ? m0Rdata : m1Rdata;
    endfunction

    function automatic logic errOf(input int p);
        return (p == 0) ? m0Err : m1Err;
    endfunction

    task automatic applyStimulus(input int p, input logic we, input logic [3:0] be,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expData, input logic expErr, input string tag);
        int n;
        setReq(p, we, be, addr, wdata);
        #1;
        checkOutput({tag, "_ready"}, (p == 0) ? m0Ready : m1Ready, 1);
        checkOutput({tag, "_memvalid"}, memValid, !expErr);
        if (!expErr) begin
            checkOutput({tag, "_memaddr"}, memAddr, addr);
            checkOutput({tag, "_memwe"}, memWe, we);
            if (we) begin
                checkOutput({tag, "_membe"}, memBe, be);
                checkOutput({tag, "_memwdata"}, memWdata, wdata);
            end
        end
        @(posedge clk); #1;
        clearReq(p);
        rrExp = (p == 0);
        n = 1;
        while (!rspValidOf(p) && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({tag, "_latency"}, n, expErr ? 1 : 2);
        checkOutput({tag, "_rdata"}, rdataOf(p), expData);
        checkOutput({tag, "_err"}, errOf(p), expErr);
        @(posedge clk); #1;
        checkOutput({tag, "_rspdone"}, rspValidOf(p), 0);
    endtask

    initial begin
        int grants, cycles, cnt0, cnt1, n;
        logic expG;
        checks = 0; failures = 0; rrExp = 1'b0;
        rstN = 1'b0; memInit = 1'b1;
        m0Valid = 1'b1; m0We = 1'b0; m0Be = 4'hF; m0Addr = MEM_BASE; m0Wdata = 32'h0; m0RspReady = 1'b1;
        m1Valid = 1'b1; m1We = 1'b0; m1Be = 4'hF; m1Addr = MEM_BASE; m1Wdata = 32'h0; m1RspReady = 1'b1;
        repeat (2) @(posedge clk);
        #1 memInit = 1'b0;

        checkOutput("rst_m0_ready", m0Ready, 0);
        checkOutput("rst_m1_ready", m1Ready, 0);
        checkOutput("rst_mem_valid", memValid, 0);
        checkOutput("rst_mem_ready", memReadyO, 0);
        checkOutput("rst_m0_rspv", m0RspValid, 0);
        checkOutput("rst_m1_rspv", m1RspValid, 0);
        clearReq(0); clearReq(1);
        rstN = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        checkOutput("mem_ready_run", memReadyO, 1);

        applyStimulus(0, 1'b0, 4'hF, MEM_BASE, 32'h0, 32'hDEAD_BEEF, 1'b0, "rd0");
        applyStimulus(1, 1'b1, 4'b0101, MEM_BASE + 32'h8, 32'h1122_3344, 32'h0, 1'b0, "wr8");
        applyStimulus(0, 1'b0, 4'hF, MEM_BASE + 32'h8, 32'h0, 32'h0022_0044, 1'b0, "rd8");
        applyStimulus(0, 1'b0, 4'hF, MEM_BASE + MEM_SIZE - 32'h4, 32'h0, 32'hCAFE_F00D, 1'b0, "rd_top");
        applyStimulus(0, 1'b0, 4'hF, MEM_BASE + MEM_SIZE, 32'h0, 32'h0, 1'b1, "err_hi");
        applyStimulus(0, 1'b0, 4'hF, MEM_BASE - 32'h4, 32'h0, 32'h0, 1'b1, "err_lo");
        applyStimulus(1, 1'b1, 4'hF, MEM_BASE + 32'h8000_0000, 32'hABCD_0123, 32'h0, 1'b1, "err_m1");

        // Both ports hammering: grants must alternate starting from the round-robin pointer
        setReq(0, 1'b0, 4'hF, MEM_BASE, 32'h0);
        setReq(1, 1'b0, 4'hF, MEM_BASE + 32'h8, 32'h0);
        #1;
        expG = rrExp; grants = 0; cycles = 0; cnt0 = 0; cnt1 = 0;
        while ((grants < 6 || (cnt0 + cnt1) < 6) && cycles < 60) begin
            if (m0RspValid) begin cnt0++; checkOutput("alt_rdata0", m0Rdata, 32'hDEAD_BEEF); end
            if (m1RspValid) begin cnt1++; checkOutput("alt_rdata1", m1Rdata, 32'h0022_0044); end
            if ((m0Ready || m1Ready) && grants < 6) begin
                checkOutput("alt_grant", m1Ready, expG);
                checkOutput("alt_onehot", m0Ready & m1Ready, 0);
                expG = ~expG;
                grants++;
                if (grants == 6) begin
                    @(posedge clk); #1;
                    clearReq(0); clearReq(1);
                    cycles++;
                    continue;
                end
            end
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("alt_grants", grants, 6);
        checkOutput("alt_cnt0", cnt0, 3);
        checkOutput("alt_cnt1", cnt1, 3);

        // Response back-pressure on port 0 blocks port 1
        m0RspReady = 1'b0;
        setReq(0, 1'b0, 4'hF, MEM_BASE + 32'h4, 32'h0);
        #1;
        checkOutput("hold_accept", m0Ready, 1);
        @(posedge clk); #1;
        clearReq(0);
        setReq(1, 1'b0, 4'hF, MEM_BASE, 32'h0);
        #1;
        checkOutput("hold_wait_m1ready", m1Ready, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_rspv", m0RspValid, 1);
            checkOutput("hold_rdata", m0Rdata, 32'h1357_9BDF);
            checkOutput("hold_m1ready", m1Ready, 0);
            @(posedge clk); #1;
        end
        m0RspReady = 1'b1;
        #1;
        checkOutput("hold_last_rspv", m0RspValid, 1);
        @(posedge clk); #1;
        checkOutput("hold_done_rspv", m0RspValid, 0);
        checkOutput("hold_m1_granted", m1Ready, 1);
        @(posedge clk); #1;
        clearReq(1);
        rrExp = 1'b0;
        n = 1;
        while (!m1RspValid && n < 8) begin @(posedge clk); #1; n++; end
        checkOutput("hold_m1_latency", n, 2);
        checkOutput("hold_m1_rdata", m1Rdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;

        // Reset asserted while the access is waiting on memory
        setReq(0, 1'b0, 4'hF, MEM_BASE, 32'h0);
        #1;
        checkOutput("rstw_accept", m0Ready, 1);
        @(posedge clk); #1;
        rstN = 1'b0;
        #1;
        checkOutput("rstw_memvalid", memValid, 0);
        checkOutput("rstw_m0ready", m0Ready, 0);
        checkOutput("rstw_m0rspv", m0RspValid, 0);
        checkOutput("rstw_m1rspv", m1RspValid, 0);
        checkOutput("rstw_memready", memReadyO, 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstw_hold_rspv", m0RspValid, 0);
        clearReq(0);
        rstN = 1'b1;
        rrExp = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            checkOutput("rstw_nostale", m0RspValid, 0);
        end
        applyStimulus(0, 1'b0, 4'hF, MEM_BASE + 32'h4, 32'h0, 32'h1357_9BDF, 1'b0, "rstw_rd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
